hs32_xmem: RTL and testbench
============================

# hs32_xmem

External memory bridge directly downstream of the CPU core's external bus (addr/rw/dout/din/valid/ready). Converts each 32-bit word access into two sequenced 16-bit async-SRAM cycles, low halfword first, with programmable wait states and device-inserted waits. Returns read data and a one-cycle `ready` pulse to the core.

## Interface
Parameters:
- `ADDR_W`, 20: external halfword address width; uses CPU `addr[ADDR_W:1]`.
- `WAIT`, 2: base strobe wait states per half (strobe lasts `WAIT+1` cycles).
- `TIMEOUT`, 255: max strobe cycles per half before forced completion (`HS32_XMEM_TIMEOUT_EN` only).

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: CPU word address; `addr[1:0]` ignored.
- `rw` in 1: 1 = write, 0 = read.
- `dtw` in 32: write data (CPU `dout`).
- `dtr` out 32: read data (CPU `din`), valid while `ready`=1.
- `valid` in 1: request; `addr`/`rw`/`dtw` stable while high.
- `ready` out 1: one-cycle completion pulse.
- `xa` out ADDR_W: external halfword address.
- `xd_o` out 16, `xd_i` in 16, `xd_oe` out 1: external data bus, split for top-level tristate.
- `xce_n`, `xoe_n`, `xwe_n` out 1: active-low chip enable, output enable, write enable.
- `xwait` in 1: device wait request, extends strobe while high.
- `err` out 1: sticky timeout flag.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE; half-select bit `hs` (0 = low).
- IDLE: on `valid`=1, latch `addr`, `rw`, `dtw`; `hs`=0; go SETUP. `valid` ignored in all other states.
- SETUP (1 cycle): `xa`={addr[ADDR_W:2],hs}; `xce_n`=0; writes drive `xd_o`=selected half and `xd_oe`=1.
- STROBE: read `xoe_n`=0, write `xwe_n`=0. Count from 0. Exit when count ≥ `WAIT` and `xwait`=0. Reads capture `xd_i` into the `hs` half of the read register on the exit cycle.
- HOLD (1 cycle): strobes high, `xce_n`=0, `xa`/`xd_o`/`xd_oe` held. If `hs`=0: `hs`=1 and go SETUP. Otherwise go DONE.
- DONE (1 cycle): `ready`=1, `dtr`=assembled word (writes: `dtr` holds last value); `xce_n`=1, `xd_oe`=0; go IDLE.
- `valid` high in the cycle after DONE starts a new access (back-to-back allowed).
- `xoe_n` and `xwe_n` are never low simultaneously. `xwe_n` is low only while `xd_oe`=1.

## Timing
- Reset values: `ready`=0, `dtr`=0, `xa`=0, `xd_o`=0, `xd_oe`=0, `xce_n`=`xoe_n`=`xwe_n`=1, `err`=0, state IDLE.
- With `valid` sampled in cycle 0 and no `xwait`: SETUP lo at 1, STROBE lo at 2..W+2, HOLD lo at W+3, SETUP hi at W+4, STROBE hi at W+5..2W+5, HOLD hi at 2W+6, `ready` at 2W+7 (W=`WAIT`; W=2 gives ready at cycle 11).
- Each `xwait` cycle asserted at or after count `WAIT` adds exactly one cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-access: next edge forces reset values and IDLE; the access is dropped with no `ready`.

## Configuration
- `HS32_XMEM_TIMEOUT_EN` defined: an 8+ bit strobe counter compares against `TIMEOUT`. On reaching it, STROBE exits regardless of `xwait`, `err` sets (sticky until reset), and a read returns `dtr`=32'hFFFF_FFFF for the whole word.
- Undefined: `xwait` may stall indefinitely; `err` is tied 0; `TIMEOUT` is unused.

## Structure
- Shared header/package `hs32_xmem_pkg`: state encodings (IDLE..DONE), the 32'hFFFF_FFFF error word, and `rw` encoding constants.
- One sub-module, `hs32_xmem_wait`: strobe counter plus `xwait`/timeout exit logic, outputs `done`/`tmo`.
- The FSM, latches and pin registers stay in `hs32_xmem`.

## Test plan
- Read, `WAIT`=2, addr=32'h0000_0010, device lo=16'hBEEF, hi=16'hDEAD → `xa`=8 then 9, `ready` at cycle 11, `dtr`=32'hDEADBEEF.
- Write dtw=32'h1234_5678 to 32'h20 → `xd_o`=16'h5678 at `xa`=16, then 16'h1234 at `xa`=17; `xwe_n` low 3 cycles per half, only while `xd_oe`=1.
- `xwait` high 4 cycles during low-half strobe → `ready` at cycle 15; data correct.
- `reset` pulsed during high-half STROBE → next cycle all strobes high, `xd_oe`=0, no `ready`; the following read completes normally.
- Back-to-back: `valid` held high across two reads → second `ready` exactly 12 cycles after the first (W=2).
- With `HS32_XMEM_TIMEOUT_EN`, `TIMEOUT`=8, `xwait` stuck high → strobe ends after 8 cycles, `err`=1, `dtr`=32'hFFFF_FFFF, `err` stays 1 until reset.

Source files
------------

// File: rtl/hs32_xmem_pkg.sv
// Shared definitions for the hs32_xmem external memory bridge: FSM states, rw encoding,
// the word returned by a timed-out read, and strobe counter sizing.
package hs32_xmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam logic        RW_READ  = 1'b0;
    localparam logic        RW_WRITE = 1'b1;
    localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

    // Counter must hold the larger of the wait and timeout limits, never fewer than 8 bits.
    function automatic int cntWidth(input int waitCycles, input int timeoutCycles);
        int maxVal;
        int w;
        maxVal = (waitCycles > timeoutCycles) ? waitCycles : timeoutCycles;
        w = 8;
        while (w < 31 && (1 << w) <= maxVal) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/hs32_xmem_if.sv
// CPU-side external bus of the hs32 core: one word request/response handshake.
// The core is the master; the memory bridge is the slave.
interface hs32_xmem_if;

    logic [31:0] addr;
    logic        rw;
    logic [31:0] dtw;
    logic [31:0] dtr;
    logic        valid;
    logic        ready;

    modport master (
        output addr,
        output rw,
        output dtw,
        output valid,
        input  dtr,
        input  ready
    );

    modport slave (
        input  addr,
        input  rw,
        input  dtw,
        input  valid,
        output dtr,
        output ready
    );

endinterface

// File: rtl/hs32_xmem_wait.sv
// Strobe length control: counts strobe cycles and decides when a half access may end.
// The forced timeout exit exists only when HS32_XMEM_TIMEOUT_EN is defined.
module hs32_xmem_wait
    import hs32_xmem_pkg::*;
#(
    parameter int WAIT    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic xwait_i,
    output logic done_o,
    output logic tmo_o
);

    localparam int               CNT_W  = cntWidth(WAIT, TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Restart from zero outside the strobe; saturate so a long device stall cannot wrap.
    always_comb begin
        count_d = count_q;
        if (!active_i) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef HS32_XMEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    assign tmo_o = active_i && (count_q >= TMO_LAST);
`else
    assign tmo_o = 1'b0;
`endif

    assign done_o = active_i && (((count_q >= WAIT_C) && !xwait_i) || tmo_o);

endmodule

// File: rtl/hs32_xmem.sv
// hs32 external memory bridge: each 32-bit CPU access becomes two 16-bit async-SRAM cycles,
// low half first. Define HS32_XMEM_TIMEOUT_EN to enable the strobe timeout and sticky err.
module hs32_xmem
    import hs32_xmem_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int WAIT    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    hs32_xmem_if.slave        cpu,
    output logic [ADDR_W-1:0] xa,
    output logic [15:0]       xd_o,
    input  logic [15:0]       xd_i,
    output logic              xd_oe,
    output logic              xce_n,
    output logic              xoe_n,
    output logic              xwe_n,
    input  logic              xwait,
    output logic              err
);

    state_t              state_q;
    logic                hs_q;
    logic                rw_q;
    logic [ADDR_W-2:0]   addr_q;
    logic [15:0]         dtwHi_q;
    logic [31:0]         rdata_q;
    logic                tmoHit_q;
    logic [31:0]         dtr_q;
    logic                ready_q;
    logic [ADDR_W-1:0]   xa_q;
    logic [15:0]         xd_o_q;
    logic                xd_oe_q;
    logic                xce_n_q;
    logic                xoe_n_q;
    logic                xwe_n_q;

    logic                stbDone;
    logic                stbTmo;
    logic [31:0]         readWord_d;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^{cpu.addr[31:ADDR_W+1], cpu.addr[1:0]};

    hs32_xmem_wait #(
        .WAIT    (WAIT),
        .TIMEOUT (TIMEOUT)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .active_i (state_q == STROBE),
        .xwait_i  (xwait),
        .done_o   (stbDone),
        .tmo_o    (stbTmo)
    );

    assign readWord_d = tmoHit_q ? ERR_WORD : rdata_q;

    // Pin registers are loaded on the edge entering each state so every output is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hs_q     <= 1'b0;
            rw_q     <= RW_READ;
            addr_q   <= '0;
            dtwHi_q  <= '0;
            rdata_q  <= '0;
            tmoHit_q <= 1'b0;
            dtr_q    <= '0;
            ready_q  <= 1'b0;
            xa_q     <= '0;
            xd_o_q   <= '0;
            xd_oe_q  <= 1'b0;
            xce_n_q  <= 1'b1;
            xoe_n_q  <= 1'b1;
            xwe_n_q  <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu.valid) begin
                        addr_q   <= cpu.addr[ADDR_W:2];
                        rw_q     <= cpu.rw;
                        dtwHi_q  <= cpu.dtw[31:16];
                        hs_q     <= 1'b0;
                        tmoHit_q <= 1'b0;
                        xa_q     <= {cpu.addr[ADDR_W:2], 1'b0};
                        xce_n_q  <= 1'b0;
                        xd_oe_q  <= (cpu.rw == RW_WRITE);
                        if (cpu.rw == RW_WRITE) begin
                            xd_o_q <= cpu.dtw[15:0];
                        end
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    xoe_n_q <= (rw_q != RW_READ);
                    xwe_n_q <= (rw_q != RW_WRITE);
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (stbDone) begin
                        xoe_n_q <= 1'b1;
                        xwe_n_q <= 1'b1;
                        if (rw_q == RW_READ) begin
                            if (hs_q) begin
                                rdata_q[31:16] <= xd_i;
                            end else begin
                                rdata_q[15:0] <= xd_i;
                            end
                        end
                        if (stbTmo) begin
                            tmoHit_q <= 1'b1;
                        end
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!hs_q) begin
                        hs_q <= 1'b1;
                        xa_q <= {addr_q, 1'b1};
                        if (rw_q == RW_WRITE) begin
                            xd_o_q <= dtwHi_q;
                        end
                        state_q <= SETUP;
                    end else begin
                        ready_q <= 1'b1;
                        if (rw_q == RW_READ) begin
                            dtr_q <= readWord_d;
                        end
                        xce_n_q <= 1'b1;
                        xd_oe_q <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HS32_XMEM_TIMEOUT_EN
    logic err_q;

    // Sticky until reset so software can discover a stalled device after the fact.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (stbTmo) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cpu.dtr   = dtr_q;
    assign cpu.ready = ready_q;
    assign xa        = xa_q;
    assign xd_o      = xd_o_q;
    assign xd_oe     = xd_oe_q;
    assign xce_n     = xce_n_q;
    assign xoe_n     = xoe_n_q;
    assign xwe_n     = xwe_n_q;

endmodule

// File: tb/tb_hs32_xmem.sv
// Scoreboard bench for hs32_xmem: stimulus queues expected read words and ready cycles,
// a monitor pops them on ready and also models the 16-bit SRAM on the external pins.
`timescale 1ns/1ps
module tb_hs32_xmem;
    import hs32_xmem_pkg::*;

    localparam int ADDR_W = 20;
    localparam int WAIT   = 2;
`ifdef HS32_XMEM_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 255;
`endif

    typedef struct {
        logic [31:0] data;
        int          cycle;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] xa;
    logic [15:0]       xd_o;
    logic [15:0]       xd_i;
    logic              xd_oe;
    logic              xce_n;
    logic              xoe_n;
    logic              xwe_n;
    logic              xwait;
    logic              err;

    hs32_xmem_if cpu();

    hs32_xmem #(
        .ADDR_W  (ADDR_W),
        .WAIT    (WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu),
        .xa    (xa),
        .xd_o  (xd_o),
        .xd_i  (xd_i),
        .xd_oe (xd_oe),
        .xce_n (xce_n),
        .xoe_n (xoe_n),
        .xwe_n (xwe_n),
        .xwait (xwait),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cycCount = 0;
    always @(posedge clk) cycCount <= cycCount + 1;

    exp_t              expQ[$];
    logic [ADDR_W-1:0] xaSeen[$];
    logic [15:0]       devMem[256];
    int                weCnt[256];
    int                vecCount  = 0;
    int                missCount = 0;

    assign xd_i = devMem[xa[7:0]];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // SRAM model, protocol invariants and ready scoreboard, all sampled on the falling edge.
    initial begin
        logic prevStrobe;
        logic strobeLow;
        exp_t e;
        prevStrobe = 1'b0;
        for (int i = 0; i < 256; i++) begin
            devMem[i] = {8'hA5, 8'(i)};
            weCnt[i]  = 0;
        end
        devMem[8] = 16'hBEEF;
        devMem[9] = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (xoe_n === 1'b0 && xwe_n === 1'b0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL strobeOverlap: xoe_n=%b xwe_n=%b, required not both 0", xoe_n, xwe_n);
            end
            if (xwe_n === 1'b0 && xd_oe !== 1'b1) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL weWithoutOe: xd_oe=%b while xwe_n=0, required 1", xd_oe);
            end
            if (xwe_n === 1'b0) begin
                devMem[xa[7:0]] = xd_o;
                weCnt[xa[7:0]]++;
            end
            strobeLow = (xoe_n === 1'b0) || (xwe_n === 1'b0);
            if (strobeLow && !prevStrobe) xaSeen.push_back(xa);
            prevStrobe = strobeLow;
            if (cpu.ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL unexpectedReady: ready=1 at cycle %0d, required 0", cycCount);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, ".dtr"}, cpu.dtr, e.data);
                    checkOutput({e.name, ".readyCycle"}, 32'(cycCount), 32'(e.cycle));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d,
                                 input logic [31:0] expData, input int extra, input string name,
                                 input bit pushExp, output int start);
        exp_t e;
        @(negedge clk);
        cpu.addr  = a;
        cpu.rw    = w;
        cpu.dtw   = d;
        cpu.valid = 1'b1;
        start     = cycCount;
        if (pushExp) begin
            e.data  = expData;
            e.cycle = start + 2 * WAIT + 7 + extra;
            e.name  = name;
            expQ.push_back(e);
        end
        @(negedge clk);
        cpu.valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL drainTimeout: %0d responses outstanding, required 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        int base;
        exp_t e;
        reset     = 1'b1;
        xwait     = 1'b0;
        cpu.addr  = '0;
        cpu.rw    = RW_READ;
        cpu.dtw   = '0;
        cpu.valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst.ready", 32'(cpu.ready), 32'd0);
        checkOutput("rst.dtr", cpu.dtr, 32'd0);
        checkOutput("rst.xa", 32'(xa), 32'd0);
        checkOutput("rst.xd_o", 32'(xd_o), 32'd0);
        checkOutput("rst.xd_oe", 32'(xd_oe), 32'd0);
        checkOutput("rst.xce_n", 32'(xce_n), 32'd1);
        checkOutput("rst.xoe_n", 32'(xoe_n), 32'd1);
        checkOutput("rst.xwe_n", 32'(xwe_n), 32'd1);
        checkOutput("rst.err", 32'(err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic read");
        base = xaSeen.size();
        applyStimulus(32'h0000_0010, RW_READ, 32'h0, 32'hDEAD_BEEF, 0, "read10", 1'b1, start);
        waitDrain(40);
        checkOutput("read10.xaLo", 32'(xaSeen[base]), 32'd8);
        checkOutput("read10.xaHi", 32'(xaSeen[base + 1]), 32'd9);

        $display("[TB] write");
        base = xaSeen.size();
        applyStimulus(32'h0000_0020, RW_WRITE, 32'h1234_5678, 32'hDEAD_BEEF, 0, "write20", 1'b1, start);
        waitDrain(40);
        checkOutput("write20.xaLo", 32'(xaSeen[base]), 32'd16);
        checkOutput("write20.xaHi", 32'(xaSeen[base + 1]), 32'd17);
        checkOutput("write20.memLo", 32'(devMem[16]), 32'h5678);
        checkOutput("write20.memHi", 32'(devMem[17]), 32'h1234);
        checkOutput("write20.weCyclesLo", 32'(weCnt[16]), 32'd3);
        checkOutput("write20.weCyclesHi", 32'(weCnt[17]), 32'd3);

        $display("[TB] read with device wait");
        applyStimulus(32'h0000_0030, RW_READ, 32'h0, 32'hA519_A518, 4, "waitRead30", 1'b1, start);
        while (cycCount < start + 4) @(negedge clk);
        xwait = 1'b1;
        while (cycCount < start + 8) @(negedge clk);
        xwait = 1'b0;
        waitDrain(40);

        $display("[TB] reset during high-half strobe");
        applyStimulus(32'h0000_0040, RW_READ, 32'h0, 32'h0, 0, "rstRead40", 1'b0, start);
        while (cycCount < start + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRst.xoe_n", 32'(xoe_n), 32'd1);
        checkOutput("midRst.xwe_n", 32'(xwe_n), 32'd1);
        checkOutput("midRst.xce_n", 32'(xce_n), 32'd1);
        checkOutput("midRst.xd_oe", 32'(xd_oe), 32'd0);
        checkOutput("midRst.ready", 32'(cpu.ready), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(32'h0000_0040, RW_READ, 32'h0, 32'hA521_A520, 0, "afterRst40", 1'b1, start);
        waitDrain(40);

        $display("[TB] back-to-back reads");
        @(negedge clk);
        cpu.addr  = 32'h0000_0020;
        cpu.rw    = RW_READ;
        cpu.valid = 1'b1;
        start     = cycCount;
        e.data = 32'h1234_5678; e.cycle = start + 11; e.name = "b2bFirst";
        expQ.push_back(e);
        e.data = 32'h1234_5678; e.cycle = start + 23; e.name = "b2bSecond";
        expQ.push_back(e);
        while (cycCount < start + 23) @(negedge clk);
        cpu.valid = 1'b0;
        waitDrain(40);

        $display("[TB] ignored address bits");
        base = xaSeen.size();
        applyStimulus(32'hFFF0_0013, RW_READ, 32'h0, 32'hDEAD_BEEF, 0, "highAddr", 1'b1, start);
        waitDrain(40);
        checkOutput("highAddr.xaLo", 32'(xaSeen[base]), 32'h0008_0008);
        checkOutput("highAddr.xaHi", 32'(xaSeen[base + 1]), 32'h0008_0009);

`ifdef HS32_XMEM_TIMEOUT_EN
        $display("[TB] strobe timeout");
        xwait = 1'b1;
        applyStimulus(32'h0000_0010, RW_READ, 32'h0, ERR_WORD, 10, "tmoRead", 1'b1, start);
        waitDrain(60);
        xwait = 1'b0;
        checkOutput("tmo.errSet", 32'(err), 32'd1);
        applyStimulus(32'h0000_0010, RW_READ, 32'h0, 32'hDEAD_BEEF, 0, "postTmoRead", 1'b1, start);
        waitDrain(40);
        checkOutput("tmo.errSticky", 32'(err), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("tmo.errCleared", 32'(err), 32'd0);
`else
        checkOutput("errTiedLow", 32'(err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
